// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: Diff = X - Y, one bit per clock, LSB first, with a single borrow flop.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output V.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d, res_q, res_d, diff_q, diff_d;
  logic             bw_q, bw_d, borrow_q, borrow_d;
  logic             accept, last, a, b, d_bit, bw_next;

  assign a       = xs_q[0];
  assign b       = ys_q[0];
  assign d_bit   = a ^ b ^ bw_q;
  assign bw_next = (~a & b) | (~(a ^ b) & bw_q);
  assign accept  = start && (state_q != RUN);
  assign last    = (state_q == RUN) && (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    bw_d     = bw_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      RUN: begin
        xs_d  = xs_q >> 1;
        ys_d  = ys_q >> 1;
        bw_d  = bw_next;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        if (last) begin
          // Only the completing edge publishes, so partial sums never reach Diff.
          state_d  = DONE;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bw_next;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = RUN;
      xs_d    = X;
      ys_d    = Y;
      cnt_d   = '0;
      bw_d    = 1'b0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      bw_q     <= 1'b0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      bw_q     <= bw_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign Diff   = diff_q;
  assign Borrow = borrow_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept aside because the shift registers consume them.
  logic xm_q, ym_q, v_q;
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      xm_q <= 1'b0;
      ym_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      if (accept) begin
        xm_q <= X[WIDTH-1];
        ym_q <= Y[WIDTH-1];
      end
      if (last) v_q <= (xm_q != ym_q) && (d_bit != xm_q);
    end
  end
  assign V = v_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor (WIDTH=4); V checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_ripple_subtractor;
  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic [3:0] Diff;
  logic       Borrow, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic       V;
`endif
  int n_pass = 0, n_total = 0;

  serial_ripple_subtractor #(.WIDTH(4), .CW(3)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .Diff(Diff), .Borrow(Borrow), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
    , .V(V)
`endif
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1); #1;
  endtask

  // Present operands and start; returns 1 ns after the accepting edge.
  task automatic start_op(input logic [3:0] x, input logic [3:0] y);
    X = x; Y = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is visible, bounded at 20.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #12;
    n_total++; if (Diff !== 4'h0) $display("FAIL reset_diff got %h want 0", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL reset_borrow got %b want 0", Borrow); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_basic();
    int n;
    start_op(4'd9, 4'd3);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else n_pass++;
    wait_done(n);
    n_total++; if (n != 4) $display("FAIL basic_latency got %0d want 4", n); else n_pass++;
    n_total++; if (Diff !== 4'd6) $display("FAIL basic_diff got %h want 6", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL basic_borrow got %b want 0", Borrow); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got %b want 0", busy); else n_pass++;
    tick(); tick();
    n_total++; if (Diff !== 4'd6) $display("FAIL basic_hold got %h want 6", Diff); else n_pass++;
  endtask

  task automatic test_borrow();
    int n;
    start_op(4'd3, 4'd9); wait_done(n);
    n_total++; if (Diff !== 4'hA) $display("FAIL b1_diff got %h want a", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b1) $display("FAIL b1_borrow got %b want 1", Borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    // 3 - (-7) = 10 does not fit in 4-bit signed
    n_total++; if (V !== 1'b1) $display("FAIL b1_v got %b want 1", V); else n_pass++;
`endif
    tick(); tick();
    start_op(4'h7, 4'hF); wait_done(n);
    n_total++; if (Diff !== 4'h8) $display("FAIL b2_diff got %h want 8", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b1) $display("FAIL b2_borrow got %b want 1", Borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    n_total++; if (V !== 1'b1) $display("FAIL b2_v got %b want 1", V); else n_pass++;
`endif
    tick(); tick();
    start_op(4'h0, 4'hF); wait_done(n);
    n_total++; if (Diff !== 4'h1) $display("FAIL b3_diff got %h want 1", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b1) $display("FAIL b3_borrow got %b want 1", Borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    n_total++; if (V !== 1'b0) $display("FAIL b3_v got %b want 0", V); else n_pass++;
`endif
    tick(); tick();
  endtask

  task automatic test_ignore();
    int n;
    start_op(4'd5, 4'd5);
    X = 4'd1; Y = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    n_total++; if (n != 3) $display("FAIL ign_latency got %0d want 3", n); else n_pass++;
    n_total++; if (Diff !== 4'h0) $display("FAIL ign_diff got %h want 0", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL ign_borrow got %b want 0", Borrow); else n_pass++;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL ign_second_op got busy=%b want 0", busy); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(4'd9, 4'd3); wait_done(n);
    start_op(4'hF, 4'h0);
    n_total++; if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy); else n_pass++;
    wait_done(n);
    n_total++; if (n != 4) $display("FAIL b2b_latency got %0d want 4", n); else n_pass++;
    n_total++; if (Diff !== 4'hF) $display("FAIL b2b_diff got %h want f", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL b2b_borrow got %b want 0", Borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    n_total++; if (V !== 1'b0) $display("FAIL b2b_v got %b want 0", V); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    start_op(4'd3, 4'd9);
    tick(); tick();
    #2 rst_n = 1'b0; #1;
    n_total++; if (Diff !== 4'h0) $display("FAIL rst_run_diff got %h want 0", Diff); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL rst_run_borrow got %b want 0", Borrow); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_run_busy got %b want 0", busy); else n_pass++;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); if (done) dones++; end
    n_total++; if (dones != 0) $display("FAIL rst_run_no_done got %0d pulses want 0", dones); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
